ulpi_reg_access: RTL and testbench
==================================

# ulpi_reg_access

ULPI link-side register access engine, clocked by the PHY's 60 MHz `clkout`. It sits directly downstream of the board's PHY reset/bring-up logic. It owns the ULPI bus (DATA, STP; observes DIR and NXT) and performs single PHY register writes and reads on request. While the PHY owns the bus, it captures RX CMD bytes for status consumers such as the LED and debug logic.

## Interface
Parameters:
- `NXT_TIMEOUT`, 255: cycles to wait for NXT after the TX CMD is driven before aborting.
- `RST_HOLD`, 16: cycles STP stays high after reset release before accepting requests.

Ports:
- `clkout`  in  1  ULPI 60 MHz clock; the only clock. One clock; reset is asynchronous and active-high.
- `rst`  in  1  asynchronous, active-high reset.
- `ulpi_dir`  in  1  PHY bus direction; 1 means the PHY drives DATA.
- `ulpi_nxt`  in  1  PHY throttle/next.
- `ulpi_data_in`  in  8  DATA pins, input side.
- `ulpi_data_out`  out  8  DATA pins, output side.
- `ulpi_data_oe`  out  1  output enable for DATA.
- `ulpi_stp`  out  1  STP pin.
- `req_valid`  in  1  request strobe.
- `req_ready`  out  1  engine idle; the request is accepted when `req_valid & req_ready`.
- `req_write`  in  1  1 = RegWrite, 0 = RegRead.
- `req_addr`  in  6  immediate register address (0x00–0x2E).
- `req_wdata`  in  8  write data.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_abort`  out  1  qualifies `rsp_valid`; set when the access was aborted.
- `rsp_rdata`  out  8  read data; valid with `rsp_valid` on a successful read.
- `rx_cmd_valid`  out  1  one-cycle pulse per captured RX CMD.
- `rx_cmd`  out  8  last captured RX CMD byte (linestate [1:0], Vbus [3:2], RxEvent [5:4], ID [6], alt_int [7]).

## Operation
- States: `HOLD`, `IDLE`, `TXCMD`, `WDATA`, `STP`, `RTURN`, `RDATA`, `WAITDIR`.
- `HOLD`: STP=1, counts `RST_HOLD` cycles, then moves to `IDLE`.
- `IDLE`:
  - `req_ready = !ulpi_dir`.
  - On accept, latch addr, data and write, then go to `TXCMD`.
- `TXCMD`:
  - Drive `{2'b10,addr}` for a write or `{2'b11,addr}` for a read.
  - On the first cycle with NXT=1: a write goes to `WDATA`, a read goes to `RTURN`.
- `WDATA`:
  - Drive wdata; hold until NXT=1, then go to `STP`.
- `STP`:
  - STP=1 and DATA=0x00 for one cycle.
  - Pulse `rsp_valid` (abort=0) and return to `IDLE`.
- `RTURN`:
  - Turnaround cycle; DATA is released. Requires DIR=1.
  - If DIR=0, end with abort.
- `RDATA`:
  - Sample `ulpi_data_in` into `rsp_rdata` when DIR=1 and NXT=0.
  - Pulse `rsp_valid` (abort=0) and go to `WAITDIR`.
- `WAITDIR`: wait for DIR=0 plus one turnaround cycle, then go to `IDLE`.
- Abort conditions:
  - DIR rises while in `TXCMD` or `WDATA`: release the bus immediately, pulse `rsp_valid` with `rsp_abort=1`, go to `WAITDIR`. There is no automatic retry.
  - NXT timeout in `TXCMD` or `WDATA`: same response, but assert STP for one cycle instead of waiting on DIR.
- RX CMD capture, in any state other than `RTURN`/`RDATA`:
  - The first DIR=1 cycle after DIR=0 is turnaround and is ignored.
  - Each following cycle with DIR=1 and NXT=0 updates `rx_cmd` and pulses `rx_cmd_valid`.
  - DIR=1 and NXT=1 cycles are packet data and are ignored.
- Output enable: `ulpi_data_oe = drive_state & !ulpi_dir`, combinational on DIR so the link releases the bus in the same cycle DIR rises. All other outputs are registered.

## Timing
- Reset values: state=`HOLD`, `ulpi_stp=1`, `ulpi_data_out=0x00`, `ulpi_data_oe=0`, `req_ready=0`, `rsp_valid=0`, `rsp_abort=0`, `rsp_rdata=0x00`, `rx_cmd_valid=0`, `rx_cmd=0x00`.
- `req_ready` first goes high `RST_HOLD`+1 cycles after `rst` deasserts, provided DIR=0.
- Write latency, with NXT answering immediately: accept → TXCMD (1) → WDATA (1) → STP (1). `rsp_valid` rises in the STP cycle, 3 cycles after accept plus any NXT wait.
- Read latency: accept → TXCMD → RTURN → RDATA. `rsp_valid` pulses 1 cycle after the RDATA sample; minimum 4 cycles from accept.
- The NXT timeout counter is 8 bits wide, loads on entry to `TXCMD`/`WDATA`, and aborts when it reaches `NXT_TIMEOUT`.
- Simultaneous `req_valid` and DIR rising in `IDLE`: the request is not accepted because `req_ready` is already low.
- `rst` asserted mid-access: all state returns to reset values immediately. No `rsp_valid` is issued for the interrupted access.

## Structure
- Package `ulpi_pkg` holds:
  - state enum;
  - TX CMD prefixes `REGW=2'b10`, `REGR=2'b11`;
  - register addresses `FUNC_CTRL=6'h04`, `IFC_CTRL=6'h07`, `OTG_CTRL=6'h0A`;
  - RX CMD field offsets.
- Sub-module `ulpi_rxcmd_capture` contains the DIR edge and turnaround tracker plus the RX CMD register. The FSM stays in the top module.

## Test plan
- Write: request addr 0x04, data 0x45; PHY raises NXT 2 cycles after TXCMD and again on WDATA. Required: DATA shows 0x84, then 0x45, then STP=1 with DATA=0x00; `rsp_valid`=1 with abort=0.
- Read: request addr 0x0A. PHY answers NXT, then DIR=1 in RTURN, then drives 0x06 with NXT=0. Required: `rsp_rdata`=0x06; OE is low from the DIR rise.
- Abort: DIR rises during WDATA. Required: OE drops in the same cycle; `rsp_valid` with `rsp_abort`=1; engine returns to IDLE after DIR falls.
- Timeout: NXT is never asserted. Required: abort after 255 cycles, one STP pulse, then `req_ready`=1.
- RX CMD: DIR rises, turnaround, then 0x4C with NXT=0. Required: one `rx_cmd_valid` pulse, `rx_cmd`=0x4C.
- Reset: assert `rst` mid-read. Required: all outputs return to reset values; `req_ready` stays low until `RST_HOLD` expires.

Source files
------------

// File: rtl/ulpi_pkg.sv
// Shared types and constants for the ULPI register access engine:
// FSM states, TX CMD prefixes, well-known PHY register addresses, RX CMD layout.
package ulpi_pkg;

    typedef enum logic [2:0] {
        HOLD,
        IDLE,
        TXCMD,
        WDATA,
        STP,
        RTURN,
        RDATA,
        WAITDIR
    } state_t;

    localparam logic [1:0] REGW = 2'b10;
    localparam logic [1:0] REGR = 2'b11;

    localparam logic [5:0] FUNC_CTRL = 6'h04;
    localparam logic [5:0] IFC_CTRL  = 6'h07;
    localparam logic [5:0] OTG_CTRL  = 6'h0A;

    // RX CMD byte layout: linestate[1:0], Vbus[3:2], RxEvent[5:4], ID[6], alt_int[7]
    localparam int RXCMD_LINESTATE_LSB = 0;
    localparam int RXCMD_VBUS_LSB      = 2;
    localparam int RXCMD_RXEVENT_LSB   = 4;
    localparam int RXCMD_ID_BIT        = 6;
    localparam int RXCMD_ALT_INT_BIT   = 7;

    function automatic logic [7:0] tx_cmd(input logic write, input logic [5:0] addr);
        return {(write ? REGW : REGR), addr};
    endfunction

endpackage

// File: rtl/ulpi_rxcmd_capture.sv
// Tracks DIR turnaround and latches RX CMD bytes sent by the PHY while it owns the bus.
module ulpi_rxcmd_capture (
    input  logic       clkout,
    input  logic       rst,
    input  logic       enable,
    input  logic       ulpi_dir,
    input  logic       ulpi_nxt,
    input  logic [7:0] ulpi_data_in,
    output logic       rx_cmd_valid,
    output logic [7:0] rx_cmd
);

    logic       dir_prev_q, dir_prev_d;
    logic       valid_q, valid_d;
    logic [7:0] cmd_q, cmd_d;

    // A DIR=1 cycle only carries an RX CMD if DIR was already high last cycle.
    always_comb begin
        dir_prev_d = ulpi_dir;
        valid_d    = enable & ulpi_dir & dir_prev_q & ~ulpi_nxt;
        cmd_d      = valid_d ? ulpi_data_in : cmd_q;
    end

    always_ff @(posedge clkout or posedge rst) begin
        if (rst) begin
            dir_prev_q <= 1'b0;
            valid_q    <= 1'b0;
            cmd_q      <= 8'h00;
        end else begin
            dir_prev_q <= dir_prev_d;
            valid_q    <= valid_d;
            cmd_q      <= cmd_d;
        end
    end

    assign rx_cmd_valid = valid_q;
    assign rx_cmd       = cmd_q;

endmodule

// File: rtl/ulpi_reg_access.sv
// ULPI link-side register access engine: single PHY register writes and reads,
// with RX CMD capture whenever the PHY owns the bus outside a register read.
module ulpi_reg_access
    import ulpi_pkg::*;
#(
    parameter int NXT_TIMEOUT = 255,
    parameter int RST_HOLD    = 16
) (
    input  logic       clkout,
    input  logic       rst,
    input  logic       ulpi_dir,
    input  logic       ulpi_nxt,
    input  logic [7:0] ulpi_data_in,
    output logic [7:0] ulpi_data_out,
    output logic       ulpi_data_oe,
    output logic       ulpi_stp,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [5:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic       rsp_abort,
    output logic [7:0] rsp_rdata,
    output logic       rx_cmd_valid,
    output logic [7:0] rx_cmd
);

    localparam int HOLD_W = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [7:0]          to_cnt_q, to_cnt_d;
    logic                turn_seen_q, turn_seen_d;
    logic                write_q, write_d;
    logic [5:0]          addr_q, addr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                stp_q, stp_d;
    logic                drive_q, drive_d;
    logic [7:0]          data_out_q, data_out_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_abort_q, rsp_abort_d;
    logic [7:0]          rsp_rdata_q, rsp_rdata_d;
    logic                timeout_hit;
    logic                rx_enable;

    assign req_ready   = (state_q == IDLE) && !ulpi_dir;
    assign timeout_hit = (to_cnt_q + 8'd1) == 8'(NXT_TIMEOUT);

    // Pin outputs are computed from the next state so they line up with state_q.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        to_cnt_d    = to_cnt_q;
        turn_seen_d = 1'b0;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_abort_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            HOLD: begin
                if (hold_cnt_q == HOLD_W'(RST_HOLD)) begin
                    state_d = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (req_valid && req_ready) begin
                    write_d  = req_write;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    to_cnt_d = 8'd0;
                    state_d  = TXCMD;
                end
            end
            TXCMD: begin
                if (ulpi_dir) begin
                    rsp_valid_d = 1'b1;
                    rsp_abort_d = 1'b1;
                    state_d     = WAITDIR;
                end else if (ulpi_nxt) begin
                    to_cnt_d = 8'd0;
                    state_d  = write_q ? WDATA : RTURN;
                end else if (timeout_hit) begin
                    rsp_valid_d = 1'b1;
                    rsp_abort_d = 1'b1;
                    state_d     = STP;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
            end
            WDATA: begin
                if (ulpi_dir) begin
                    rsp_valid_d = 1'b1;
                    rsp_abort_d = 1'b1;
                    state_d     = WAITDIR;
                end else if (ulpi_nxt) begin
                    rsp_valid_d = 1'b1;
                    state_d     = STP;
                end else if (timeout_hit) begin
                    rsp_valid_d = 1'b1;
                    rsp_abort_d = 1'b1;
                    state_d     = STP;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
            end
            STP: begin
                state_d = IDLE;
            end
            RTURN: begin
                if (ulpi_dir) begin
                    state_d = RDATA;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_abort_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            RDATA: begin
                if (!ulpi_dir) begin
                    rsp_valid_d = 1'b1;
                    rsp_abort_d = 1'b1;
                    state_d     = IDLE;
                end else if (!ulpi_nxt) begin
                    rsp_rdata_d = ulpi_data_in;
                    rsp_valid_d = 1'b1;
                    state_d     = WAITDIR;
                end
            end
            WAITDIR: begin
                // DIR must be seen low for a turnaround cycle before the bus is ours again.
                if (!ulpi_dir) begin
                    if (turn_seen_q) begin
                        state_d = IDLE;
                    end else begin
                        turn_seen_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = HOLD;
            end
        endcase

        stp_d   = (state_d == HOLD) || (state_d == STP);
        drive_d = (state_d == IDLE) || (state_d == TXCMD) ||
                  (state_d == WDATA) || (state_d == STP);
        case (state_d)
            TXCMD:   data_out_d = tx_cmd(write_d, addr_d);
            WDATA:   data_out_d = wdata_d;
            default: data_out_d = 8'h00;
        endcase
    end

    always_ff @(posedge clkout or posedge rst) begin
        if (rst) begin
            state_q     <= HOLD;
            hold_cnt_q  <= '0;
            to_cnt_q    <= 8'd0;
            turn_seen_q <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= 6'h00;
            wdata_q     <= 8'h00;
            stp_q       <= 1'b1;
            drive_q     <= 1'b0;
            data_out_q  <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_abort_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            to_cnt_q    <= to_cnt_d;
            turn_seen_q <= turn_seen_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            stp_q       <= stp_d;
            drive_q     <= drive_d;
            data_out_q  <= data_out_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_abort_q <= rsp_abort_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Releasing on DIR combinationally avoids a bus fight in the cycle the PHY takes over.
    assign ulpi_data_oe  = drive_q & ~ulpi_dir;
    assign ulpi_data_out = data_out_q;
    assign ulpi_stp      = stp_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_abort     = rsp_abort_q;
    assign rsp_rdata     = rsp_rdata_q;

    assign rx_enable = (state_q != RTURN) && (state_q != RDATA);

    ulpi_rxcmd_capture u_rxcmd (
        .clkout       (clkout),
        .rst          (rst),
        .enable       (rx_enable),
        .ulpi_dir     (ulpi_dir),
        .ulpi_nxt     (ulpi_nxt),
        .ulpi_data_in (ulpi_data_in),
        .rx_cmd_valid (rx_cmd_valid),
        .rx_cmd       (rx_cmd)
    );

endmodule

// File: tb/tb_ulpi_reg_access.sv
// Directed self-checking bench for ulpi_reg_access: write, read, DIR abort,
// NXT timeout, RX CMD capture and mid-access reset.
module tb_ulpi_reg_access;
    import ulpi_pkg::*;

    localparam int RST_HOLD_CYC = 16;

    logic       clkout = 1'b0;
    logic       rst;
    logic       ulpi_dir;
    logic       ulpi_nxt;
    logic [7:0] ulpi_data_in;
    logic [7:0] ulpi_data_out;
    logic       ulpi_data_oe;
    logic       ulpi_stp;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [5:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_abort;
    logic [7:0] rsp_rdata;
    logic       rx_cmd_valid;
    logic [7:0] rx_cmd;

    int testsRun  = 0;
    int failCount = 0;

    always #5 clkout = ~clkout;

    ulpi_reg_access #(
        .NXT_TIMEOUT (255),
        .RST_HOLD    (RST_HOLD_CYC)
    ) dut (
        .clkout        (clkout),
        .rst           (rst),
        .ulpi_dir      (ulpi_dir),
        .ulpi_nxt      (ulpi_nxt),
        .ulpi_data_in  (ulpi_data_in),
        .ulpi_data_out (ulpi_data_out),
        .ulpi_data_oe  (ulpi_data_oe),
        .ulpi_stp      (ulpi_stp),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_abort     (rsp_abort),
        .rsp_rdata     (rsp_rdata),
        .rx_cmd_valid  (rx_cmd_valid),
        .rx_cmd        (rx_cmd)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clkout);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic write, input logic [5:0] addr,
                                 input logic [7:0] wdata);
        req_valid = valid;
        req_write = write;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    task automatic checkResetValues(input string prefix);
        checkOutput({prefix, "_stp"},       32'(ulpi_stp),      32'h1);
        checkOutput({prefix, "_data_out"},  32'(ulpi_data_out), 32'h00);
        checkOutput({prefix, "_oe"},        32'(ulpi_data_oe),  32'h0);
        checkOutput({prefix, "_req_ready"}, 32'(req_ready),     32'h0);
        checkOutput({prefix, "_rsp_valid"}, 32'(rsp_valid),     32'h0);
        checkOutput({prefix, "_rsp_abort"}, 32'(rsp_abort),     32'h0);
        checkOutput({prefix, "_rsp_rdata"}, 32'(rsp_rdata),     32'h00);
        checkOutput({prefix, "_rx_valid"},  32'(rx_cmd_valid),  32'h0);
        checkOutput({prefix, "_rx_cmd"},    32'(rx_cmd),        32'h00);
    endtask

    task automatic waitReady(input int maxCycles, input string tag);
        int n = 0;
        while (!req_ready && n < maxCycles) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(req_ready), 32'h1);
    endtask

    task automatic holdPeriod(input string prefix);
        logic sawValid = 1'b0;
        for (int i = 0; i < RST_HOLD_CYC; i++) begin
            tick();
            if (rsp_valid) sawValid = 1'b1;
        end
        checkOutput({prefix, "_ready_held"}, 32'(req_ready), 32'h0);
        checkOutput({prefix, "_stp_held"},   32'(ulpi_stp),  32'h1);
        checkOutput({prefix, "_no_rsp"},     32'(sawValid),  32'h0);
        tick();
        checkOutput({prefix, "_ready"},      32'(req_ready), 32'h1);
        checkOutput({prefix, "_stp_low"},    32'(ulpi_stp),  32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not reach the end");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst          = 1'b1;
        ulpi_dir     = 1'b0;
        ulpi_nxt     = 1'b0;
        ulpi_data_in = 8'h00;
        applyStimulus(1'b0, 1'b0, 6'h00, 8'h00);
        repeat (3) @(posedge clkout);
        #1;
        checkResetValues("reset");

        rst = 1'b0;
        holdPeriod("boot");

        // Register write to FUNC_CTRL, NXT arrives on the third TX CMD cycle
        applyStimulus(1'b1, 1'b1, FUNC_CTRL, 8'h45);
        tick();
        applyStimulus(1'b0, 1'b0, 6'h00, 8'h00);
        checkOutput("wr_txcmd",      32'(ulpi_data_out), 32'h84);
        checkOutput("wr_txcmd_oe",   32'(ulpi_data_oe),  32'h1);
        checkOutput("wr_busy",       32'(req_ready),     32'h0);
        tick();
        checkOutput("wr_txcmd_hold", 32'(ulpi_data_out), 32'h84);
        tick();
        ulpi_nxt = 1'b1;
        tick();
        checkOutput("wr_wdata",      32'(ulpi_data_out), 32'h45);
        checkOutput("wr_wdata_stp",  32'(ulpi_stp),      32'h0);
        tick();
        ulpi_nxt = 1'b0;
        checkOutput("wr_stp",        32'(ulpi_stp),      32'h1);
        checkOutput("wr_stp_data",   32'(ulpi_data_out), 32'h00);
        checkOutput("wr_rsp_valid",  32'(rsp_valid),     32'h1);
        checkOutput("wr_rsp_abort",  32'(rsp_abort),     32'h0);
        tick();
        checkOutput("wr_rsp_pulse",  32'(rsp_valid),     32'h0);
        checkOutput("wr_stp_done",   32'(ulpi_stp),      32'h0);
        checkOutput("wr_ready",      32'(req_ready),     32'h1);

        // Register read of OTG_CTRL returning 0x06
        applyStimulus(1'b1, 1'b0, OTG_CTRL, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b0, 6'h00, 8'h00);
        checkOutput("rd_txcmd",      32'(ulpi_data_out), 32'hCA);
        ulpi_nxt = 1'b1;
        tick();
        ulpi_nxt = 1'b0;
        ulpi_dir = 1'b1;
        #1;
        checkOutput("rd_rturn_oe",   32'(ulpi_data_oe),  32'h0);
        tick();
        ulpi_data_in = 8'h06;
        checkOutput("rd_rdata_oe",   32'(ulpi_data_oe),  32'h0);
        checkOutput("rd_no_rsp_yet", 32'(rsp_valid),     32'h0);
        tick();
        checkOutput("rd_rsp_valid",  32'(rsp_valid),     32'h1);
        checkOutput("rd_rsp_abort",  32'(rsp_abort),     32'h0);
        checkOutput("rd_rdata",      32'(rsp_rdata),     32'h06);
        checkOutput("rd_no_rxcmd",   32'(rx_cmd_valid),  32'h0);
        ulpi_dir     = 1'b0;
        ulpi_data_in = 8'h00;
        tick();
        checkOutput("rd_turnaround", 32'(req_ready),     32'h0);
        waitReady(8, "rd_idle");

        // DIR rises during WDATA of a write to IFC_CTRL
        applyStimulus(1'b1, 1'b1, IFC_CTRL, 8'h12);
        tick();
        applyStimulus(1'b0, 1'b0, 6'h00, 8'h00);
        checkOutput("ab_txcmd",      32'(ulpi_data_out), 32'h87);
        ulpi_nxt = 1'b1;
        tick();
        ulpi_nxt = 1'b0;
        checkOutput("ab_wdata",      32'(ulpi_data_out), 32'h12);
        checkOutput("ab_wdata_oe",   32'(ulpi_data_oe),  32'h1);
        ulpi_dir = 1'b1;
        #1;
        checkOutput("ab_oe_drop",    32'(ulpi_data_oe),  32'h0);
        tick();
        checkOutput("ab_rsp_valid",  32'(rsp_valid),     32'h1);
        checkOutput("ab_rsp_abort",  32'(rsp_abort),     32'h1);
        ulpi_nxt     = 1'b1;
        ulpi_data_in = 8'hAA;
        tick();
        checkOutput("ab_rsp_pulse",  32'(rsp_valid),     32'h0);
        checkOutput("ab_pkt_ignore", 32'(rx_cmd_valid),  32'h0);
        checkOutput("ab_ready_low",  32'(req_ready),     32'h0);
        ulpi_dir     = 1'b0;
        ulpi_nxt     = 1'b0;
        ulpi_data_in = 8'h00;
        waitReady(8, "ab_idle");

        // RX CMD capture, with a request colliding with the DIR rise
        ulpi_dir     = 1'b1;
        ulpi_data_in = 8'hFF;
        applyStimulus(1'b1, 1'b1, FUNC_CTRL, 8'h55);
        #1;
        checkOutput("rx_ready_low",  32'(req_ready),     32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 6'h00, 8'h00);
        checkOutput("rx_turnaround", 32'(rx_cmd_valid),  32'h0);
        checkOutput("rx_no_accept",  32'(ulpi_data_out), 32'h00);
        ulpi_data_in = 8'h4C;
        tick();
        checkOutput("rx_valid",      32'(rx_cmd_valid),  32'h1);
        checkOutput("rx_cmd",        32'(rx_cmd),        32'h4C);
        ulpi_data_in = 8'h99;
        ulpi_nxt     = 1'b1;
        tick();
        checkOutput("rx_pulse",      32'(rx_cmd_valid),  32'h0);
        checkOutput("rx_cmd_hold",   32'(rx_cmd),        32'h4C);
        ulpi_dir     = 1'b0;
        ulpi_nxt     = 1'b0;
        ulpi_data_in = 8'h00;
        tick();
        checkOutput("rx_ready_back", 32'(req_ready),     32'h1);
        checkOutput("rx_no_rsp",     32'(rsp_valid),     32'h0);

        // NXT never arrives on a read of 0x2E
        applyStimulus(1'b1, 1'b0, 6'h2E, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b0, 6'h00, 8'h00);
        checkOutput("to_txcmd",      32'(ulpi_data_out), 32'hEE);
        n = 0;
        while (!rsp_valid && n < 300) begin
            tick();
            n++;
        end
        checkOutput("to_cycles",     32'(n),             32'd255);
        checkOutput("to_rsp_abort",  32'(rsp_abort),     32'h1);
        checkOutput("to_stp",        32'(ulpi_stp),      32'h1);
        tick();
        checkOutput("to_stp_once",   32'(ulpi_stp),      32'h0);
        checkOutput("to_rsp_pulse",  32'(rsp_valid),     32'h0);
        checkOutput("to_ready",      32'(req_ready),     32'h1);

        // Reset asserted in the middle of a read
        applyStimulus(1'b1, 1'b0, OTG_CTRL, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b0, 6'h00, 8'h00);
        ulpi_nxt = 1'b1;
        tick();
        ulpi_nxt = 1'b0;
        ulpi_dir = 1'b1;
        tick();
        ulpi_data_in = 8'h33;
        ulpi_dir     = 1'b0;
        rst          = 1'b1;
        #1;
        checkResetValues("midrst");
        ulpi_data_in = 8'h00;
        tick();
        rst = 1'b0;
        holdPeriod("midrst");

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
